// File: rtl/v_mem_access_if.sv
// Data-memory port bundle: request/grant/rvalid handshake plus 512-bit data paths.
interface v_mem_access_if #(
  parameter int unsigned AW = 64,
  parameter int unsigned DW = 512
);
  logic          mem_req_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic          mem_gnt_i;
  logic          mem_rvalid_i;
  logic [DW-1:0] mem_rdata_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );
endinterface

// File: rtl/v_mem_access.sv
// Vector memory-access stage: one load/store at a time over a req/gnt/rvalid port,
// optional per-element scaling of load data, one or two registered VRF writebacks.
module v_mem_access #(
  parameter int unsigned VMEM_DW    = 512,
  parameter int unsigned VMEM_AW    = 64,
  parameter int unsigned VREG_AW    = 5,
  parameter int unsigned VALUOP_DW  = 5,
  parameter int unsigned LINE_BYTES = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 issue_valid_i,
  output logic                 issue_ready_o,
  input  logic                 vmem_ren_i,
  input  logic                 vmem_wen_i,
  input  logic [VMEM_AW-1:0]   vmem_addr_i,
  input  logic [VMEM_DW-1:0]   vmem_din_i,
  input  logic [VALUOP_DW-1:0] vmem_opcode_i,
  input  logic [31:0]          vmem_vs2select_i,
  input  logic                 wb_en_i,
  input  logic [VREG_AW-1:0]   wb_addr_i,
  input  logic                 wb_double_i,
  v_mem_access_if.master       mem,
  output logic                 vwb_en_o,
  output logic [VREG_AW-1:0]   vwb_addr_o,
  output logic [VMEM_DW-1:0]   vwb_data_o,
  output logic                 busy_o
);

  localparam int unsigned EL_W   = 32;
  localparam int unsigned NUM_EL = VMEM_DW / EL_W;
  localparam logic [VALUOP_DW-1:0] OP_SCALED = VALUOP_DW'(5);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_WB} state_e;

  state_e               state_q, state_d;
  logic                 we_q, we_d;
  logic [VMEM_AW-1:0]   addr_q, addr_d;
  logic [VMEM_DW-1:0]   wdata_q, wdata_d;
  logic [VALUOP_DW-1:0] opcode_q, opcode_d;
  logic [31:0]          vs2_q, vs2_d;
  logic                 wb_en_q, wb_en_d;
  logic [VREG_AW-1:0]   vd_q, vd_d;
  logic                 double_q, double_d;
  logic                 half_q, half_d;
  logic [VREG_AW-1:0]   vwb_addr_q, vwb_addr_d;
  logic [VMEM_DW-1:0]   vwb_data_q, vwb_data_d;
  logic [VMEM_DW-1:0]   scaled;
  logic                 accept;
  logic                 mem_req;
  logic                 ready;
  logic                 busy;
  logic                 vwb_en;

  assign accept = issue_valid_i & (state_q == S_IDLE);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept && (vmem_ren_i || vmem_wen_i)) state_d = S_REQ;
      S_REQ:  if (mem.mem_gnt_i) state_d = we_q ? S_IDLE : S_WAIT;
      S_WAIT: if (mem.mem_rvalid_i) state_d = S_WB;
      S_WB:   state_d = (double_q && !half_q) ? S_REQ : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    mem_req = 1'b0;
    ready   = 1'b0;
    busy    = 1'b1;
    vwb_en  = 1'b0;
    case (state_q)
      S_IDLE: begin ready = 1'b1; busy = 1'b0; end
      S_REQ:  mem_req = 1'b1;
      S_WB:   vwb_en = wb_en_q;
      default: ;
    endcase
  end

  // Low 32 bits of a product are identical for signed and unsigned operands,
  // so this gives the wrapping signed multiply per element.
  always_comb begin
    scaled = '0;
    for (int i = 0; i < int'(NUM_EL); i++) begin
      scaled[EL_W*i +: EL_W] = mem.mem_rdata_i[EL_W*i +: EL_W] * vs2_q;
    end
  end

  // Captured request fields and writeback datapath
  always_comb begin
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    opcode_d   = opcode_q;
    vs2_d      = vs2_q;
    wb_en_d    = wb_en_q;
    vd_d       = vd_q;
    double_d   = double_q;
    half_d     = half_q;
    vwb_addr_d = vwb_addr_q;
    vwb_data_d = vwb_data_q;
    if (accept) begin
      we_d     = vmem_wen_i;
      addr_d   = vmem_addr_i;
      wdata_d  = vmem_din_i;
      opcode_d = vmem_opcode_i;
      vs2_d    = vmem_vs2select_i;
      wb_en_d  = wb_en_i;
      vd_d     = wb_addr_i;
      double_d = wb_double_i;
      half_d   = 1'b0;
    end
    if (state_q == S_WAIT && mem.mem_rvalid_i) begin
      vwb_data_d = (opcode_q == OP_SCALED) ? scaled : mem.mem_rdata_i;
      vwb_addr_d = vd_q + VREG_AW'(half_q);
    end
    if (state_q == S_WB && double_q && !half_q) begin
      half_d = 1'b1;
      addr_d = addr_q + VMEM_AW'(LINE_BYTES);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      opcode_q   <= '0;
      vs2_q      <= '0;
      wb_en_q    <= 1'b0;
      vd_q       <= '0;
      double_q   <= 1'b0;
      half_q     <= 1'b0;
      vwb_addr_q <= '0;
      vwb_data_q <= '0;
    end else begin
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      opcode_q   <= opcode_d;
      vs2_q      <= vs2_d;
      wb_en_q    <= wb_en_d;
      vd_q       <= vd_d;
      double_q   <= double_d;
      half_q     <= half_d;
      vwb_addr_q <= vwb_addr_d;
      vwb_data_q <= vwb_data_d;
    end
  end

  assign issue_ready_o   = ready;
  assign busy_o          = busy;
  assign vwb_en_o        = vwb_en;
  assign vwb_addr_o      = vwb_addr_q;
  assign vwb_data_o      = vwb_data_q;
  assign mem.mem_req_o   = mem_req;
  assign mem.mem_we_o    = we_q;
  assign mem.mem_addr_o  = addr_q;
  assign mem.mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_v_mem_access.sv
// Directed bench for v_mem_access: loads, double loads, scaled loads, stores, reset abort.
module tb_v_mem_access;
  logic         clk;
  logic         rst;
  logic         issue_valid_i;
  logic         issue_ready_o;
  logic         vmem_ren_i;
  logic         vmem_wen_i;
  logic [63:0]  vmem_addr_i;
  logic [511:0] vmem_din_i;
  logic [4:0]   vmem_opcode_i;
  logic [31:0]  vmem_vs2select_i;
  logic         wb_en_i;
  logic [4:0]   wb_addr_i;
  logic         wb_double_i;
  logic         vwb_en_o;
  logic [4:0]   vwb_addr_o;
  logic [511:0] vwb_data_o;
  logic         busy_o;

  int checks   = 0;
  int failures = 0;

  logic [511:0] pat_a, pat_b, pat_c, pat_d, pat_s, exp_s;

  v_mem_access_if #(.AW(64), .DW(512)) mif ();

  v_mem_access dut (
    .clk              (clk),
    .rst              (rst),
    .issue_valid_i    (issue_valid_i),
    .issue_ready_o    (issue_ready_o),
    .vmem_ren_i       (vmem_ren_i),
    .vmem_wen_i       (vmem_wen_i),
    .vmem_addr_i      (vmem_addr_i),
    .vmem_din_i       (vmem_din_i),
    .vmem_opcode_i    (vmem_opcode_i),
    .vmem_vs2select_i (vmem_vs2select_i),
    .wb_en_i          (wb_en_i),
    .wb_addr_i        (wb_addr_i),
    .wb_double_i      (wb_double_i),
    .mem              (mif),
    .vwb_en_o         (vwb_en_o),
    .vwb_addr_o       (vwb_addr_o),
    .vwb_data_o       (vwb_data_o),
    .busy_o           (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic ren, input logic wen, input logic [63:0] addr,
                       input logic [511:0] din, input logic [4:0] op, input logic [31:0] vs2,
                       input logic wben, input logic [4:0] vd, input logic dbl);
    issue_valid_i    = 1'b1;
    vmem_ren_i       = ren;
    vmem_wen_i       = wen;
    vmem_addr_i      = addr;
    vmem_din_i       = din;
    vmem_opcode_i    = op;
    vmem_vs2select_i = vs2;
    wb_en_i          = wben;
    wb_addr_i        = vd;
    wb_double_i      = dbl;
    step();
    issue_valid_i    = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    issue_valid_i = 1'b0; vmem_ren_i = 1'b0; vmem_wen_i = 1'b0;
    vmem_addr_i = '0; vmem_din_i = '0; vmem_opcode_i = '0; vmem_vs2select_i = '0;
    wb_en_i = 1'b0; wb_addr_i = '0; wb_double_i = 1'b0;
    mif.mem_gnt_i = 1'b0; mif.mem_rvalid_i = 1'b0; mif.mem_rdata_i = '0;

    pat_a = {16{32'hA5A5_0001}};
    pat_b = {16{32'hB0B0_1111}};
    pat_c = {16{32'hC3C3_2222}};
    pat_d = {16{32'hDEAD_BEEF}};
    pat_s = '0;
    pat_s[31:0]   = 32'h0000_0001;
    pat_s[63:32]  = 32'h7FFF_FFFF;
    pat_s[95:64]  = 32'hFFFF_FFFF;
    pat_s[127:96] = 32'h1000_0000;
    exp_s = '0;
    exp_s[31:0]   = 32'hFFFF_FFFE;
    exp_s[63:32]  = 32'h0000_0002;
    exp_s[95:64]  = 32'h0000_0002;
    exp_s[127:96] = 32'hE000_0000;

    // Reset state
    #12;
    chk("rst_req", 512'(mif.mem_req_o), 512'(1'b0));
    chk("rst_busy", 512'(busy_o), 512'(1'b0));
    chk("rst_vwb_en", 512'(vwb_en_o), 512'(1'b0));
    chk("rst_addr", 512'(mif.mem_addr_o), 512'(64'h0));
    @(negedge clk); rst = 1'b1;
    step();
    chk("rst_ready", 512'(issue_ready_o), 512'(1'b1));

    // Plain load, vd=3
    issue(1'b1, 1'b0, 64'h8080_0000, '0, 5'd0, 32'd0, 1'b1, 5'd3, 1'b0);
    chk("ld_req", 512'(mif.mem_req_o), 512'(1'b1));
    chk("ld_we", 512'(mif.mem_we_o), 512'(1'b0));
    chk("ld_addr", 512'(mif.mem_addr_o), 512'(64'h8080_0000));
    chk("ld_ready_req", 512'(issue_ready_o), 512'(1'b0));
    mif.mem_gnt_i = 1'b1; step(); mif.mem_gnt_i = 1'b0;
    chk("ld_req_wait", 512'(mif.mem_req_o), 512'(1'b0));
    chk("ld_ready_wait", 512'(issue_ready_o), 512'(1'b0));
    step();
    chk("ld_no_wb_early", 512'(vwb_en_o), 512'(1'b0));
    mif.mem_rvalid_i = 1'b1; mif.mem_rdata_i = pat_a; step(); mif.mem_rvalid_i = 1'b0;
    chk("ld_wb_en", 512'(vwb_en_o), 512'(1'b1));
    chk("ld_wb_addr", 512'(vwb_addr_o), 512'(5'd3));
    chk("ld_wb_data", vwb_data_o, pat_a);
    chk("ld_ready_wb", 512'(issue_ready_o), 512'(1'b0));
    step();
    chk("ld_wb_done", 512'(vwb_en_o), 512'(1'b0));
    chk("ld_ready_back", 512'(issue_ready_o), 512'(1'b1));
    chk("ld_data_held", vwb_data_o, pat_a);

    // Double load, vd=31 wraps to 0 on the second half
    issue(1'b1, 1'b0, 64'h8080_3000, '0, 5'd0, 32'd0, 1'b1, 5'd31, 1'b1);
    chk("dl_addr0", 512'(mif.mem_addr_o), 512'(64'h8080_3000));
    mif.mem_gnt_i = 1'b1; step(); mif.mem_gnt_i = 1'b0;
    mif.mem_rvalid_i = 1'b1; mif.mem_rdata_i = pat_b; step(); mif.mem_rvalid_i = 1'b0;
    chk("dl_wb0_en", 512'(vwb_en_o), 512'(1'b1));
    chk("dl_wb0_addr", 512'(vwb_addr_o), 512'(5'd31));
    chk("dl_wb0_data", vwb_data_o, pat_b);
    step();
    chk("dl_req1", 512'(mif.mem_req_o), 512'(1'b1));
    chk("dl_addr1", 512'(mif.mem_addr_o), 512'(64'h8080_3040));
    chk("dl_ready1", 512'(issue_ready_o), 512'(1'b0));
    mif.mem_gnt_i = 1'b1; step(); mif.mem_gnt_i = 1'b0;
    mif.mem_rvalid_i = 1'b1; mif.mem_rdata_i = pat_c; step(); mif.mem_rvalid_i = 1'b0;
    chk("dl_wb1_en", 512'(vwb_en_o), 512'(1'b1));
    chk("dl_wb1_addr", 512'(vwb_addr_o), 512'(5'd0));
    chk("dl_wb1_data", vwb_data_o, pat_c);
    step();
    chk("dl_ready_back", 512'(issue_ready_o), 512'(1'b1));
    chk("dl_no_third_req", 512'(mif.mem_req_o), 512'(1'b0));

    // Scaled load by -2
    issue(1'b1, 1'b0, 64'h100, '0, 5'd5, 32'hFFFF_FFFE, 1'b1, 5'd7, 1'b0);
    mif.mem_gnt_i = 1'b1; step(); mif.mem_gnt_i = 1'b0;
    mif.mem_rvalid_i = 1'b1; mif.mem_rdata_i = pat_s; step(); mif.mem_rvalid_i = 1'b0;
    chk("sc_wb_addr", 512'(vwb_addr_o), 512'(5'd7));
    chk("sc_wb_data", vwb_data_o, exp_s);
    step();

    // Store with grant held off for four cycles; ren and double ignored
    issue(1'b1, 1'b1, 64'h0000_0000_0000_1000, pat_d, 5'd0, 32'd0, 1'b1, 5'd4, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("st_req", 512'(mif.mem_req_o), 512'(1'b1));
      chk("st_we", 512'(mif.mem_we_o), 512'(1'b1));
      chk("st_addr", 512'(mif.mem_addr_o), 512'(64'h1000));
      chk("st_wdata", mif.mem_wdata_o, pat_d);
      chk("st_no_wb", 512'(vwb_en_o), 512'(1'b0));
      if (i < 3) step();
    end
    mif.mem_gnt_i = 1'b1; step(); mif.mem_gnt_i = 1'b0;
    chk("st_ready", 512'(issue_ready_o), 512'(1'b1));
    chk("st_req_off", 512'(mif.mem_req_o), 512'(1'b0));
    chk("st_no_wb_after", 512'(vwb_en_o), 512'(1'b0));
    step();
    chk("st_idle", 512'(busy_o), 512'(1'b0));

    // Request that is neither load nor store is dropped
    issue(1'b0, 1'b0, 64'h2000, '0, 5'd0, 32'd0, 1'b1, 5'd1, 1'b0);
    chk("nop_ready", 512'(issue_ready_o), 512'(1'b1));
    chk("nop_req", 512'(mif.mem_req_o), 512'(1'b0));
    chk("nop_busy", 512'(busy_o), 512'(1'b0));

    // Load with writeback disabled
    issue(1'b1, 1'b0, 64'h3000, '0, 5'd0, 32'd0, 1'b0, 5'd9, 1'b0);
    chk("nowb_req", 512'(mif.mem_req_o), 512'(1'b1));
    mif.mem_gnt_i = 1'b1; step(); mif.mem_gnt_i = 1'b0;
    mif.mem_rvalid_i = 1'b1; mif.mem_rdata_i = pat_b; step(); mif.mem_rvalid_i = 1'b0;
    chk("nowb_en", 512'(vwb_en_o), 512'(1'b0));
    chk("nowb_busy", 512'(busy_o), 512'(1'b1));
    step();
    chk("nowb_ready", 512'(issue_ready_o), 512'(1'b1));

    // Reset while waiting for read data aborts the load
    issue(1'b1, 1'b0, 64'h4000, '0, 5'd0, 32'd0, 1'b1, 5'd12, 1'b0);
    mif.mem_gnt_i = 1'b1; step(); mif.mem_gnt_i = 1'b0;
    chk("ab_in_wait", 512'(busy_o), 512'(1'b1));
    rst = 1'b0;
    #2;
    chk("ab_rst_busy", 512'(busy_o), 512'(1'b0));
    chk("ab_rst_data", vwb_data_o, 512'(0));
    @(negedge clk); rst = 1'b1;
    mif.mem_rvalid_i = 1'b1; mif.mem_rdata_i = pat_c;
    step();
    chk("ab_no_wb", 512'(vwb_en_o), 512'(1'b0));
    step(); mif.mem_rvalid_i = 1'b0;
    chk("ab_no_wb2", 512'(vwb_en_o), 512'(1'b0));
    chk("ab_ready", 512'(issue_ready_o), 512'(1'b1));
    chk("ab_data", vwb_data_o, 512'(0));
    chk("ab_addr", 512'(vwb_addr_o), 512'(5'd0));
    chk("ab_req", 512'(mif.mem_req_o), 512'(1'b0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
